// File: rtl/fp_mul_seq.sv
// fp_mul_seq: parametrised IEEE-754 multiplier, one significand bit per cycle.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b operands;
//        out_valid/out_ready + result, flags {invalid, overflow, underflow,
//        inexact}; busy high whenever the FSM is not idle.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         busy
);

    localparam int SIG_W = MAN_W + 1;
    localparam int ACC_W = 2 * SIG_W;
    localparam int EW    = EXP_W + 2;
    localparam int MR_W  = MAN_W + 1;
    localparam int CNT_W = $clog2(SIG_W);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN    =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        RND,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d;
    logic [SIG_W-1:0]   sig_a_q, sig_a_d;
    logic [SIG_W-1:0]   sig_b_q, sig_b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]      exp_q, exp_d;
    logic [MAN_W-1:0]   man_q, man_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic [W-1:0]       res_q, res_d;
    logic [3:0]         flags_q, flags_d;

    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
    logic               sign_in;
    logic               inc;
    logic [MR_W-1:0]    man_r;
    logic [EW-1:0]      exp_r;

    assign ea      = a[W-2 -: EXP_W];
    assign eb      = b[W-2 -: EXP_W];
    assign ma      = a[MAN_W-1:0];
    assign mb      = b[MAN_W-1:0];
    assign sign_in = a[W-1] ^ b[W-1];

    // Exponent field 0 is zero; subnormals flush silently.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);
    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
    assign flags     = flags_q;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        spec_d   = spec_q;
        sig_a_d  = sig_a_q;
        sig_b_d  = sig_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        res_d    = res_q;
        flags_d  = flags_q;
        inc      = 1'b0;
        man_r    = '0;
        exp_r    = exp_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_in;
                    sig_a_d = {1'b1, ma};
                    sig_b_d = {1'b1, mb};
                    acc_d   = '0;
                    cnt_d   = '0;
                    exp_d   = EW'(ea) + EW'(eb) - EW'(BIAS);
                    spec_d  = 1'b1;
                    state_d = MUL;
                    // Special results are fixed now; MUL only spends
                    // one cycle forwarding them to DONE.
                    if (a_nan | b_nan | (a_inf & b_zero) |
                        (a_zero & b_inf)) begin
                        res_d   = QNAN;
                        flags_d = 4'b1000;
                    end else if (a_inf | b_inf) begin
                        res_d   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_d = 4'b0000;
                    end else if (a_zero | b_zero) begin
                        res_d   = {sign_in, {(W-1){1'b0}}};
                        flags_d = 4'b0000;
                    end else begin
                        spec_d = 1'b0;
                    end
                end
            end
            MUL: begin
                if (spec_q) begin
                    state_d = DONE;
                end else begin
                    if (sig_b_q[cnt_q]) begin
                        acc_d = acc_q + (ACC_W'(sig_a_q) << cnt_q);
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SIG_W - 1)) begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                // Product of two [1,2) significands lies in [1,4).
                if (acc_q[ACC_W-1]) begin
                    exp_d    = exp_q + EW'(1);
                    man_d    = acc_q[ACC_W-2 -: MAN_W];
                    guard_d  = acc_q[MAN_W];
                    sticky_d = |acc_q[MAN_W-1:0];
                end else begin
                    man_d    = acc_q[ACC_W-3 -: MAN_W];
                    guard_d  = acc_q[MAN_W-1];
                    sticky_d = |acc_q[MAN_W-2:0];
                end
                state_d = RND;
            end
            RND: begin
                inc   = guard_q & (sticky_q | man_q[0]);
                man_r = {1'b0, man_q} + MR_W'(inc);
                // A carry leaves the mantissa field at zero.
                exp_r = exp_q + EW'(man_r[MAN_W]);
                if (!exp_r[EW-1] && (exp_r >= EXP_MAX)) begin
                    res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (exp_r[EW-1] || (exp_r == '0)) begin
                    res_d   = {sign_q, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    res_d   = {sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
                    flags_d = {3'b000, guard_q | sticky_q};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            spec_q   <= 1'b0;
            sig_a_q  <= '0;
            sig_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            spec_q   <= spec_d;
            sig_a_q  <= sig_a_d;
            sig_b_q  <= sig_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for single- and half-precision fp_mul_seq.
// Drives on the falling edge, samples 1 ns after the rising edge.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic [31:0] a_s, b_s, result_s;
    logic [3:0]  flags_s;

    logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h, busy_h;
    logic [15:0] a_h, b_h, result_h;
    logic [3:0]  flags_h;

    fp_mul_seq u_sp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .a         (a_s),
        .b         (b_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .result    (result_s),
        .flags     (flags_s),
        .busy      (busy_s)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_h),
        .in_ready  (in_ready_h),
        .a         (a_h),
        .b         (b_h),
        .out_valid (out_valid_h),
        .out_ready (out_ready_h),
        .result    (result_h),
        .flags     (flags_h),
        .busy      (busy_h)
    );

    typedef struct {
        bit          half;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vs [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Accept one operand pair, wait for out_valid, check it, optionally take.
    task automatic run_vec(input string name, input vec_t v, input bit take);
        int cyc;
        bit rdy_seen;
        @(negedge clk);
        if (v.half) begin
            in_valid_h = 1'b1;
            a_h = v.a[15:0];
            b_h = v.b[15:0];
        end else begin
            in_valid_s = 1'b1;
            a_s = v.a;
            b_s = v.b;
        end
        @(posedge clk);
        #1;
        in_valid_h = 1'b0;
        in_valid_s = 1'b0;
        a_s = $urandom;
        b_s = $urandom;
        a_h = 16'($urandom);
        b_h = 16'($urandom);
        cyc = 0;
        rdy_seen = 1'b0;
        while (!(v.half ? out_valid_h : out_valid_s) && cyc < 200) begin
            if (v.half ? in_ready_h : in_ready_s) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'(v.lat));
        chk({name, " in_ready_low"}, 32'(rdy_seen), 32'd0);
        chk({name, " result"},
            v.half ? {16'h0, result_h} : result_s, v.r);
        chk({name, " flags"},
            v.half ? {28'h0, flags_h} : {28'h0, flags_s}, {28'h0, v.f});
        if (take) begin
            @(negedge clk);
            out_ready_s = 1'b1;
            out_ready_h = 1'b1;
            @(posedge clk);
            #1;
            out_ready_s = 1'b0;
            out_ready_h = 1'b0;
            chk({name, " out_valid_drop"},
                32'(v.half ? out_valid_h : out_valid_s), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        bit   stale;

        vs[0]  = '{0, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 26};
        vs[1]  = '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26};
        vs[2]  = '{0, 32'hBFC00000, 32'h3FC00000, 32'hC0100000, 4'b0000, 26};
        vs[3]  = '{0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 26};
        vs[4]  = '{0, 32'h0D800000, 32'h0D800000, 32'h00000000, 4'b0011, 26};
        vs[5]  = '{0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1};
        vs[6]  = '{0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1};
        vs[7]  = '{0, 32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001, 26};
        vs[8]  = '{0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26};
        vs[9]  = '{0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 26};
        vs[10] = '{0, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001, 26};
        vs[11] = '{0, 32'h20000000, 32'h20000000, 32'h00800000, 4'b0000, 26};
        vs[12] = '{0, 32'h20000000, 32'h1F800000, 32'h00000000, 4'b0011, 26};
        vs[13] = '{0, 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 26};
        vs[14] = '{0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1};
        vs[15] = '{0, 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1};
        vs[16] = '{0, 32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000, 1};
        vs[17] = '{0, 32'hFF800001, 32'h00000000, 32'h7FC00000, 4'b1000, 1};
        vs[18] = '{0, 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000, 1};
        vs[19] = '{1, 32'h00003C00, 32'h0000C000, 32'h0000C000, 4'b0000, 13};
        vs[20] = '{1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101, 13};
        vs[21] = '{1, 32'h00007C00, 32'h00000000, 32'h00007E00, 4'b1000, 1};

        rst_n = 1'b0;
        in_valid_s = 1'b0; out_ready_s = 1'b0; a_s = '0; b_s = '0;
        in_valid_h = 1'b0; out_ready_h = 1'b0; a_h = '0; b_h = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid_s), 32'd0);
        chk("rst result", result_s, 32'h0);
        chk("rst flags", {28'h0, flags_s}, 32'h0);
        chk("rst busy", 32'(busy_s), 32'd0);
        chk("rst in_ready", 32'(in_ready_s), 32'd1);
        chk("rst hp in_ready", 32'(in_ready_h), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("vec%0d", i), vs[i], 1'b1);
        end

        // Result held while consumer stalls; extra in_valid ignored.
        run_vec("hold", vs[0], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid_s = (k == 2);
            a_s = 32'h3F800000;
            b_s = 32'h3F800000;
            @(posedge clk);
            #1;
            in_valid_s = 1'b0;
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid_s), 32'd1);
            chk($sformatf("hold%0d result", k), result_s, 32'h40F00000);
            chk($sformatf("hold%0d flags", k), {28'h0, flags_s}, 32'h0);
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready_s), 32'd0);
        end
        @(negedge clk);
        out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        chk("hold taken out_valid", 32'(out_valid_s), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold pulse ignored busy", 32'(busy_s), 32'd0);

        // Reset while the shift-add loop is at cnt=10.
        @(negedge clk);
        in_valid_s = 1'b1;
        a_s = 32'h40400000;
        b_s = 32'h40200000;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst out_valid", 32'(out_valid_s), 32'd0);
        chk("midrst busy", 32'(busy_s), 32'd0);
        chk("midrst in_ready", 32'(in_ready_s), 32'd1);
        chk("midrst result", result_s, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_s || busy_s) stale = 1'b1;
        end
        chk("midrst no stale", 32'(stale), 32'd0);
        v = vs[7];
        run_vec("post_rst", v, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
